// File: rtl/cei_obi_mailbox_pkg.sv
// Shared types and constants for the inter-hart OBI mailbox.
package cei_mochila_pkg;

  localparam logic [31:0] MBX_BASE_ADDR     = 32'h1A40_0000;

  localparam logic [3:0]  MBX_DATA_OFFSET   = 4'h0;
  localparam logic [3:0]  MBX_STATUS_OFFSET = 4'h4;
  localparam logic [3:0]  MBX_IRQ_EN_OFFSET = 4'h8;

  localparam logic [1:0]  MBX_DATA_SEL      = MBX_DATA_OFFSET[3:2];
  localparam logic [1:0]  MBX_STATUS_SEL    = MBX_STATUS_OFFSET[3:2];
  localparam logic [1:0]  MBX_IRQ_EN_SEL    = MBX_IRQ_EN_OFFSET[3:2];

  localparam int STATUS_EMPTY_BIT = 8;
  localparam int STATUS_FULL_BIT  = 9;
  localparam int STATUS_OVF_BIT   = 10;
  localparam int STATUS_UNF_BIT   = 11;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage

// File: rtl/cei_obi_mailbox_if.sv
// OBI request/response bundle between the cores' data ports and the mailbox.
interface cei_obi_mailbox_if;
  import cei_mochila_pkg::*;

  obi_req_t  slave_req;
  obi_resp_t slave_resp;

  modport slave  (input  slave_req, output slave_resp);
  modport master (output slave_req, input  slave_resp);
endinterface

// File: rtl/cei_obi_mailbox_fifo.sv
// Single-hart word queue; flags overflow/underflow attempts as one-cycle pulses.
module cei_mailbox_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [W-1:0]               i_wdata,
  output logic [W-1:0]               o_rdata,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_empty,
  output logic                       o_full,
  output logic                       o_ovf,
  output logic                       o_unf
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic          w_push_ok, w_pop_ok;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));
  assign w_push_ok = i_push & ~o_full;
  assign w_pop_ok  = i_pop & ~o_empty;
  assign o_ovf     = i_push & o_full;
  assign o_unf     = i_pop & o_empty;
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rptr];

  // Storage deliberately has no reset; only the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (w_push_ok) r_mem[r_wptr] <= i_wdata;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop_ok)  r_rptr <= r_rptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/cei_obi_mailbox.sv
// Inter-hart mailbox OBI target: per-hart queues, sticky error flags, level IRQs.
// Build option CEI_MAILBOX_OVF_IRQ_EN: sticky errors also hold the hart's IRQ high.
module cei_obi_mailbox
  import cei_mochila_pkg::*;
#(
  parameter int NHARTS = 3,
  parameter int DEPTH  = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  cei_obi_mailbox_if.slave  bus,
  output logic [NHARTS-1:0] irq_o
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              w_req, w_we;
  logic [1:0]        w_hart, w_reg;
  logic [31:0]       w_wdata, w_rdata;
  logic              w_unused;

  logic [NHARTS-1:0] w_sel, w_push, w_pop, w_wr_status, w_wr_irq_en;
  logic [NHARTS-1:0] w_empty, w_full, w_ovf_ev, w_unf_ev, w_irq_nxt;
  logic [31:0]       w_head  [NHARTS];
  logic [CW-1:0]     w_count [NHARTS];

  logic [NHARTS-1:0] r_ovf, r_unf, r_irq_en, r_irq;
  logic              r_rvalid;
  logic [31:0]       r_rdata;

  assign w_req    = bus.slave_req.req;
  assign w_we     = bus.slave_req.we;
  assign w_hart   = bus.slave_req.addr[5:4];
  assign w_reg    = bus.slave_req.addr[3:2];
  assign w_wdata  = bus.slave_req.wdata;
  assign w_unused = ^{bus.slave_req.be, bus.slave_req.addr[31:6], bus.slave_req.addr[1:0]};

  // Hart indices at or above NHARTS match no w_sel bit, so they touch nothing.
  for (genvar h = 0; h < NHARTS; h++) begin : g_hart
    assign w_sel[h]       = w_req & (w_hart == 2'(h));
    assign w_push[h]      = w_sel[h] &  w_we & (w_reg == MBX_DATA_SEL);
    assign w_pop[h]       = w_sel[h] & ~w_we & (w_reg == MBX_DATA_SEL);
    assign w_wr_status[h] = w_sel[h] &  w_we & (w_reg == MBX_STATUS_SEL);
    assign w_wr_irq_en[h] = w_sel[h] &  w_we & (w_reg == MBX_IRQ_EN_SEL);

    cei_mailbox_fifo #(.DEPTH(DEPTH), .W(32)) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .i_push  (w_push[h]),
      .i_pop   (w_pop[h]),
      .i_wdata (w_wdata),
      .o_rdata (w_head[h]),
      .o_count (w_count[h]),
      .o_empty (w_empty[h]),
      .o_full  (w_full[h]),
      .o_ovf   (w_ovf_ev[h]),
      .o_unf   (w_unf_ev[h])
    );
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ovf    <= '0;
      r_unf    <= '0;
      r_irq_en <= '0;
    end else begin
      for (int h = 0; h < NHARTS; h++) begin
        if (w_ovf_ev[h])
          r_ovf[h] <= 1'b1;
        else if (w_wr_status[h] & w_wdata[STATUS_OVF_BIT])
          r_ovf[h] <= 1'b0;
        if (w_unf_ev[h])
          r_unf[h] <= 1'b1;
        else if (w_wr_status[h] & w_wdata[STATUS_UNF_BIT])
          r_unf[h] <= 1'b0;
        if (w_wr_irq_en[h])
          r_irq_en[h] <= w_wdata[0];
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    for (int h = 0; h < NHARTS; h++) begin
      if (w_hart == 2'(h)) begin
        if (w_reg == MBX_DATA_SEL) begin
          w_rdata = w_empty[h] ? '0 : w_head[h];
        end else if (w_reg == MBX_STATUS_SEL) begin
          w_rdata[7:0]             = 8'(w_count[h]);
          w_rdata[STATUS_EMPTY_BIT] = w_empty[h];
          w_rdata[STATUS_FULL_BIT]  = w_full[h];
          w_rdata[STATUS_OVF_BIT]   = r_ovf[h];
          w_rdata[STATUS_UNF_BIT]   = r_unf[h];
        end else if (w_reg == MBX_IRQ_EN_SEL) begin
          w_rdata[0] = r_irq_en[h];
        end
      end
    end
  end

`ifdef CEI_MAILBOX_OVF_IRQ_EN
  assign w_irq_nxt = r_irq_en & (~w_empty | r_ovf | r_unf);
`else
  assign w_irq_nxt = r_irq_en & ~w_empty;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_irq    <= '0;
    end else begin
      r_rvalid <= w_req;
      r_rdata  <= (w_req & ~w_we) ? w_rdata : '0;
      r_irq    <= w_irq_nxt;
    end
  end

  assign bus.slave_resp = '{gnt: w_req, rvalid: r_rvalid, rdata: r_rdata};
  assign irq_o          = r_irq;
endmodule

// File: tb/tb_cei_obi_mailbox.sv
// Directed bench for cei_obi_mailbox; read data checked through an expected-response queue.
module tb_cei_obi_mailbox;
  import cei_mochila_pkg::*;

  localparam int NHARTS = 3;
  localparam int DEPTH  = 4;

  typedef struct {
    logic        chk;
    logic [31:0] d;
  } exp_t;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic [NHARTS-1:0] irq_o;
  logic              exp_rv;
  exp_t              exp_q[$];
  logic [31:0]       mq[$];
  int                n_cmp = 0, n_err = 0;
  int                mon_cmp = 0, mon_err = 0;

  cei_obi_mailbox_if bus ();

  cei_obi_mailbox #(.NHARTS(NHARTS), .DEPTH(DEPTH)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus),
    .irq_o  (irq_o)
  );

  always #5 clk_i = ~clk_i;

  // Every granted request owes exactly one rvalid on the following cycle.
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) exp_rv <= 1'b0;
    else         exp_rv <= bus.slave_req.req;
  end

  always @(negedge clk_i) begin
    exp_t e;
    mon_cmp++;
    assert (bus.slave_resp.rvalid === exp_rv) else begin
      mon_err++;
      $error("FAIL rvalid observed=%0b expected=%0b", bus.slave_resp.rvalid, exp_rv);
    end
    if (bus.slave_resp.rvalid === 1'b1) begin
      mon_cmp++;
      assert (exp_q.size() != 0) else begin
        mon_err++;
        $error("FAIL unexpected_rvalid observed=1 expected=0");
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if (e.chk) begin
          mon_cmp++;
          assert (bus.slave_resp.rdata === e.d) else begin
            mon_err++;
            $error("FAIL rdata observed=%08h expected=%08h", bus.slave_resp.rdata, e.d);
          end
        end
      end
    end else begin
      mon_cmp++;
      assert (bus.slave_resp.rdata === 32'h0) else begin
        mon_err++;
        $error("FAIL rdata_idle observed=%08h expected=00000000", bus.slave_resp.rdata);
      end
    end
  end

  function automatic logic [31:0] a(input int h, input logic [3:0] off);
    return MBX_BASE_ADDR | (32'(h) << 4) | {28'd0, off};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                     input logic chk, input logic [31:0] exp);
    exp_t e;
    bus.slave_req.req   = 1'b1;
    bus.slave_req.we    = we;
    bus.slave_req.be    = 4'hF;
    bus.slave_req.addr  = addr;
    bus.slave_req.wdata = wd;
    e.chk = chk;
    e.d   = exp;
    exp_q.push_back(e);
    #1;
    check("gnt", {31'd0, bus.slave_resp.gnt}, 32'd1);
    @(posedge clk_i);
    #1;
    bus.slave_req.req = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] wd);
    txn(1'b1, addr, wd, 1'b0, 32'h0);
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp);
    txn(1'b0, addr, 32'h0, 1'b1, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  initial begin
    logic [31:0] w;
    bus.slave_req = '0;
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    idle(1);

    check("reset_irq", 32'(irq_o), 32'h0);
    check("idle_gnt", {31'd0, bus.slave_resp.gnt}, 32'h0);
    rd(a(0, MBX_STATUS_OFFSET), 32'h100);

    // Interrupt follows one cycle behind the queue becoming non-empty / empty.
    wr(a(1, MBX_IRQ_EN_OFFSET), 32'h1);
    rd(a(1, MBX_IRQ_EN_OFFSET), 32'h1);
    wr(a(1, MBX_DATA_OFFSET), 32'hCAFE_0001);
    check("irq1_before", 32'(irq_o[1]), 32'h0);
    idle(1);
    check("irq1_set", 32'(irq_o[1]), 32'h1);
    rd(a(1, MBX_DATA_OFFSET), 32'hCAFE_0001);
    idle(1);
    check("irq1_clear", 32'(irq_o[1]), 32'h0);

    // Overflow on hart 2: fifth push is dropped.
    for (int i = 0; i < 5; i++) wr(a(2, MBX_DATA_OFFSET), 32'hB000_0000 + 32'(i));
    rd(a(2, MBX_STATUS_OFFSET), 32'h604);
    for (int i = 0; i < 4; i++) rd(a(2, MBX_DATA_OFFSET), 32'hB000_0000 + 32'(i));
    rd(a(2, MBX_STATUS_OFFSET), 32'h500);
    wr(a(2, MBX_STATUS_OFFSET), 32'h400);
    rd(a(2, MBX_STATUS_OFFSET), 32'h100);

    // Underflow on hart 0 and its W1C clear.
    wr(a(0, MBX_IRQ_EN_OFFSET), 32'h1);
    rd(a(0, MBX_DATA_OFFSET), 32'h0);
    rd(a(0, MBX_STATUS_OFFSET), 32'h900);
    idle(1);
`ifdef CEI_MAILBOX_OVF_IRQ_EN
    check("irq0_unf_held", 32'(irq_o[0]), 32'h1);
`else
    check("irq0_unf_held", 32'(irq_o[0]), 32'h0);
`endif
    wr(a(0, MBX_STATUS_OFFSET), 32'h800);
    idle(2);
    check("irq0_after_w1c", 32'(irq_o[0]), 32'h0);
    rd(a(0, MBX_STATUS_OFFSET), 32'h100);

    // DEPTH+2 pushes interleaved with pops to wrap the pointers.
    for (int i = 0; i < DEPTH + 2; i++) begin
      w = 32'hA000_0000 + 32'(i);
      wr(a(0, MBX_DATA_OFFSET), w);
      mq.push_back(w);
      if (i % 2 == 1) rd(a(0, MBX_DATA_OFFSET), mq.pop_front());
      rd(a(0, MBX_STATUS_OFFSET), 32'(mq.size()) | ((mq.size() == 0) ? 32'h100 : 32'h0));
    end
    while (mq.size() != 0) rd(a(0, MBX_DATA_OFFSET), mq.pop_front());
    rd(a(0, MBX_STATUS_OFFSET), 32'h100);

    // Hart index beyond NHARTS is inert.
    wr(a(3, MBX_DATA_OFFSET), 32'h1234_5678);
    wr(a(3, MBX_IRQ_EN_OFFSET), 32'h1);
    wr(a(3, MBX_STATUS_OFFSET), 32'hC00);
    rd(a(3, MBX_DATA_OFFSET), 32'h0);
    rd(a(3, MBX_STATUS_OFFSET), 32'h0);
    rd(a(3, MBX_IRQ_EN_OFFSET), 32'h0);
    for (int h = 0; h < NHARTS; h++) rd(a(h, MBX_STATUS_OFFSET), 32'h100);
    idle(1);
    check("irq_all_idle", 32'(irq_o), 32'h0);

    // Reset lands while a read response is due.
    wr(a(1, MBX_DATA_OFFSET), 32'hD000_0001);
    wr(a(1, MBX_DATA_OFFSET), 32'hD000_0002);
    idle(2);
    check("irq1_pre_reset", 32'(irq_o[1]), 32'h1);
    bus.slave_req.req   = 1'b1;
    bus.slave_req.we    = 1'b0;
    bus.slave_req.addr  = a(1, MBX_DATA_OFFSET);
    bus.slave_req.wdata = 32'h0;
    @(posedge clk_i);
    #1 rst_ni = 1'b0;
    bus.slave_req.req = 1'b0;
    #1;
    check("rvalid_in_reset", {31'd0, bus.slave_resp.rvalid}, 32'h0);
    check("irq_in_reset", 32'(irq_o), 32'h0);
    idle(2);
    rst_ni = 1'b1;
    idle(2);
    for (int h = 0; h < NHARTS; h++) rd(a(h, MBX_STATUS_OFFSET), 32'h100);
    rd(a(0, MBX_IRQ_EN_OFFSET), 32'h0);
    rd(a(1, MBX_IRQ_EN_OFFSET), 32'h0);
    idle(2);
    check("irq_post_reset", 32'(irq_o), 32'h0);
    check("responses_drained", 32'(exp_q.size()), 32'h0);

    n_cmp += mon_cmp;
    n_err += mon_err;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/cei_obi_mailbox.md
# cei_obi_mailbox

OBI subordinate that gives the three cve2 harts a hardware inter-core mailbox: one word FIFO per hart, written by any hart and drained by its owner. Sits on the system bus as a target for the cores' data ports. Drives one level interrupt per hart into that hart's fast-interrupt vector when its queue holds data. It is the responder end of the core data-port OBI protocol, with per-hart interrupt return paths.

## Interface
- NHARTS, 3: number of hart queues; legal 1..4.
- DEPTH, 4: words per queue; power of two, 2..128.
- clk_i  input  1  system clock.
- rst_ni  input  1  reset; one clock, asynchronous, active-low.
- slave_req_i  input  obi_req_t  OBI request: req, we, be, addr, wdata.
- slave_resp_o  output  obi_resp_t  OBI response: gnt, rvalid, rdata.
- irq_o  output  NHARTS  per-hart mailbox interrupt, level, active-high.

## Operation
- Decode: addr[5:4] = hart index h; addr[3:2] = register; other bits ignored. be ignored, full-word access only.
- Register 0x0 DATA: write pushes wdata into queue h; read pops the head of queue h and returns it.
- Register 0x4 STATUS: [7:0] count, [8] empty, [9] full, [10] overflow sticky, [11] underflow sticky, rest 0. Write: bits 10/11 are W1C, all other bits ignored.
- Register 0x8 IRQ_EN: bit0 enable, read/write; other bits read 0.
- Register 0xC: reads 0, writes ignored.
- Push to a full queue: data dropped, count unchanged, overflow set.
- Pop from an empty queue: rdata = 0, count unchanged, underflow set.
- h >= NHARTS: writes ignored, reads return 0, no flags touched.
- Queue: circular buffer with read/write pointers of clog2(DEPTH) bits that wrap modulo DEPTH. Count is clog2(DEPTH)+1 bits.
- irq_o[h] (registered) = IRQ_EN[h] & ~empty[h].

## Timing
- Always ready: gnt = req, combinationally, every cycle.
- One transaction per cycle. Each granted transaction, read or write, produces exactly one rvalid pulse on the next cycle.
- rdata is registered and valid only while rvalid=1; it is 0 otherwise.
- Back-to-back requests give back-to-back rvalid, in order.
- State updates (push, pop, flag set/clear, IRQ_EN) occur at the clock edge of the grant cycle.
- A STATUS read in cycle N+1 reflects the effect of a transaction granted in cycle N.
- irq_o changes one cycle after the state change that causes it; pop-to-empty deasserts irq_o on the cycle after the pop's grant edge.
- A transaction that sets a sticky flag and a W1C clear of that flag cannot coincide, because there is a single port.
- Reset values: all pointers and counts 0, empty=1, flags 0, IRQ_EN 0, rvalid 0, rdata 0, irq_o 0. FIFO storage is not reset.
- Reset asserted mid-transaction drops any pending rvalid; no response follows.

## Configuration
- CEI_MAILBOX_OVF_IRQ_EN defined: irq_o[h] = IRQ_EN[h] & (~empty[h] | overflow[h] | underflow[h]), so an error keeps the interrupt raised until the flag is cleared by W1C.
- Macro undefined: irq_o depends only on non-empty; flags are visible in STATUS only.

## Structure
- cei_mochila_pkg holds:
  - register offsets MBX_DATA_OFFSET, MBX_STATUS_OFFSET, MBX_IRQ_EN_OFFSET;
  - STATUS bit positions;
  - the mailbox base address constant.
- Sub-module cei_mailbox_fifo, instantiated NHARTS times:
  - push/pop/data ports; count/empty/full outputs;
  - overflow/underflow event pulses;
  - parameter DEPTH.
- Top level holds the address decode, sticky flags, IRQ_EN, response registers and the irq registers.

## Test plan
- Reset, then read STATUS of hart 0 → rvalid one cycle after gnt, rdata=0x100 (empty), irq_o=0.
- Set IRQ_EN[1]=1, write 0xCAFE0001 to hart-1 DATA → irq_o[1]=1 one cycle after the grant edge. Read hart-1 DATA → 0xCAFE0001. irq_o[1]=0 one cycle after the pop.
- Push 5 words to hart-2 with DEPTH=4 → STATUS = 0x604 (count 4, full, overflow). Pop 4 → data in push order; the 5th word is absent.
- Pop empty hart-0 → rdata 0, STATUS bit11 set. Write 0x800 to STATUS → bit11 cleared. With CEI_MAILBOX_OVF_IRQ_EN and IRQ_EN=1, irq_o[0] stays high until that clear.
- Push DEPTH+2 words interleaved with pops (wrap-around) → order preserved, count never exceeds DEPTH. Access hart index 3 → reads 0, no state change.
- Assert rst_ni low while rvalid is due → no rvalid after reset; all queues empty.
